// File: rtl/cordic_input_stage_if.sv
// Sample bus of the cosine CORDIC input stage: float operand in, Q8.16 value plus Q1.22 angle out.
// master = producer/consumer side (bench or upstream), slave = the stage itself.
interface cordic_input_stage_if;
  logic        in_valid;
  logic [31:0] dataa;
  logic        out_valid;
  logic [23:0] x_fixed;
  logic [23:0] theta;
  logic        range_err;
  logic        err_sticky;

  modport master (
    output in_valid, dataa,
    input  out_valid, x_fixed, theta, range_err, err_sticky
  );

  modport slave (
    input  in_valid, dataa,
    output out_valid, x_fixed, theta, range_err, err_sticky
  );
endinterface

// File: rtl/cordic_input_stage.sv
// Float-to-fixed front end of the cosine CORDIC: 3 clk_en-qualified stages, no backpressure beyond clk_en.
// Optional CORDIC_INPUT_ROUND_EN makes the float-to-Q8.16 shift round half-up instead of truncating.
module cordic_input_stage (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  cordic_input_stage_if.slave   bus
);

  // Stage 1: unpacked operand and class flags
  logic        v1_q, v1_d;
  logic [7:0]  e1_q, e1_d;
  logic [23:0] m1_q, m1_d;
  logic        zero1_q, zero1_d;
  logic        neg1_q, neg1_d;
  logic        big1_q, big1_d;

  // Stage 2: converted magnitude
  logic        v2_q, v2_d;
  logic [23:0] x2_q, x2_d;
  logic        err2_q, err2_d;

  // Stage 3: outputs
  logic        v3_q, v3_d;
  logic [23:0] x3_q, x3_d;
  logic [23:0] th3_q, th3_d;
  logic        err3_q, err3_d;
  logic        sticky_q, sticky_d;

  logic [7:0]  shamt;
  logic [23:0] conv;
`ifdef CORDIC_INPUT_ROUND_EN
  logic [24:0] ext;
  logic [24:0] rsum;
`endif
  logic signed [24:0] diff;

  always_comb begin
    // Shift distance that lines the Q1.23 mantissa up with the Q8.16 LSB.
    shamt = 8'd134 - e1_q;
`ifdef CORDIC_INPUT_ROUND_EN
    ext   = {m1_q, 1'b0} >> shamt;
    rsum  = {1'b0, ext[24:1]} + {24'd0, ext[0]};
    conv  = rsum[24] ? 24'hFFFFFF : rsum[23:0];
`else
    conv  = m1_q >> shamt;
`endif
    diff  = $signed({1'b0, x2_q}) - 25'sh0800000;
  end

  always_comb begin
    v1_d     = v1_q;
    e1_d     = e1_q;
    m1_d     = m1_q;
    zero1_d  = zero1_q;
    neg1_d   = neg1_q;
    big1_d   = big1_q;
    v2_d     = v2_q;
    x2_d     = x2_q;
    err2_d   = err2_q;
    v3_d     = v3_q;
    x3_d     = x3_q;
    th3_d    = th3_q;
    err3_d   = err3_q;
    sticky_d = sticky_q;

    if (clk_en) begin
      v1_d    = bus.in_valid;
      e1_d    = bus.dataa[30:23];
      m1_d    = {1'b1, bus.dataa[22:0]};
      zero1_d = (bus.dataa[30:23] == 8'd0);
      neg1_d  = bus.dataa[31] && (bus.dataa[30:23] != 8'd0);
      big1_d  = (bus.dataa[30:23] >= 8'd135);

      v2_d   = v1_q;
      err2_d = 1'b0;
      // Zero outranks sign so that -0.0 is a clean zero, and sign outranks big so -Inf/NaN read as negative.
      if (zero1_q) begin
        x2_d = 24'd0;
      end else if (neg1_q) begin
        x2_d   = 24'd0;
        err2_d = 1'b1;
      end else if (big1_q) begin
        x2_d   = 24'hFFFFFF;
        err2_d = 1'b1;
      end else begin
        x2_d = conv;
      end

      v3_d     = v2_q;
      x3_d     = x2_q;
      th3_d    = 24'(diff >>> 1);
      err3_d   = err2_q;
      sticky_d = sticky_q | (v2_q & err2_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q     <= 1'b0;
      e1_q     <= 8'd0;
      m1_q     <= 24'd0;
      zero1_q  <= 1'b0;
      neg1_q   <= 1'b0;
      big1_q   <= 1'b0;
      v2_q     <= 1'b0;
      x2_q     <= 24'd0;
      err2_q   <= 1'b0;
      v3_q     <= 1'b0;
      x3_q     <= 24'd0;
      th3_q    <= 24'd0;
      err3_q   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      e1_q     <= e1_d;
      m1_q     <= m1_d;
      zero1_q  <= zero1_d;
      neg1_q   <= neg1_d;
      big1_q   <= big1_d;
      v2_q     <= v2_d;
      x2_q     <= x2_d;
      err2_q   <= err2_d;
      v3_q     <= v3_d;
      x3_q     <= x3_d;
      th3_q    <= th3_d;
      err3_q   <= err3_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.out_valid  = v3_q;
  assign bus.x_fixed    = x3_q;
  assign bus.theta      = th3_q;
  assign bus.range_err  = err3_q;
  assign bus.err_sticky = sticky_q;

endmodule

// File: tb/tb_cordic_input_stage.sv
// Directed bench for cordic_input_stage: nominal, boundary, out-of-range, rounding, stall and reset cases.
module tb_cordic_input_stage;

  logic clk;
  logic reset;
  logic clk_en;

  cordic_input_stage_if bus ();

  cordic_input_stage dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // 0, 25, 50 ... 250 as IEEE-754 singles
  logic [31:0] stall_vec [11] = '{
    32'h00000000, 32'h41C80000, 32'h42480000, 32'h42960000, 32'h42C80000, 32'h42FA0000,
    32'h43160000, 32'h432F0000, 32'h43480000, 32'h43610000, 32'h437A0000
  };

`ifdef CORDIC_INPUT_ROUND_EN
  localparam logic [23:0] ROUND_EXP = 24'h000001;
`else
  localparam logic [23:0] ROUND_EXP = 24'h000000;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [23:0] ex,
                         input logic [23:0] et, input logic er, input logic es);
    chk1({tag, ".out_valid"}, {23'd0, bus.out_valid}, {23'd0, ev});
    chk1({tag, ".err_sticky"}, {23'd0, bus.err_sticky}, {23'd0, es});
    if (ev) begin
      chk1({tag, ".x_fixed"}, bus.x_fixed, ex);
      chk1({tag, ".theta"}, bus.theta, et);
      chk1({tag, ".range_err"}, {23'd0, bus.range_err}, {23'd0, er});
    end
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, ".out_valid"}, {23'd0, bus.out_valid}, 24'd0);
    chk1({tag, ".x_fixed"}, bus.x_fixed, 24'd0);
    chk1({tag, ".theta"}, bus.theta, 24'd0);
    chk1({tag, ".range_err"}, {23'd0, bus.range_err}, 24'd0);
    chk1({tag, ".err_sticky"}, {23'd0, bus.err_sticky}, 24'd0);
  endtask

  task automatic send(input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.dataa    = d;
    step();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.dataa    = 32'h0;
    step();
  endtask

  function automatic logic [23:0] exp_theta(input logic [23:0] x);
    logic signed [24:0] d;
    d = $signed({1'b0, x}) - 25'sh0800000;
    return d[24:1];
  endfunction

  int          pipe [3];
  int          k;
  logic        en;
  logic [23:0] xe;

  initial begin
    reset        = 1'b1;
    clk_en       = 1'b1;
    bus.in_valid = 1'b0;
    bus.dataa    = 32'h0;
    step();
    step();
    chk_zero("reset");
    reset = 1'b0;

    // Nominal back-to-back samples
    send(32'h41C80000);
    send(32'h43000000);
    send(32'h437F0000);
    chk_out("nom25", 1'b1, 24'h190000, 24'hCC8000, 1'b0, 1'b0);
    idle();
    chk_out("nom128", 1'b1, 24'h800000, 24'h000000, 1'b0, 1'b0);
    idle();
    chk_out("nom255", 1'b1, 24'hFF0000, 24'h3F8000, 1'b0, 1'b0);
    idle();
    chk_out("bubble", 1'b0, 24'h0, 24'h0, 1'b0, 1'b0);

    // Zero and negative zero
    send(32'h00000000);
    idle();
    idle();
    chk_out("zero", 1'b1, 24'h000000, 24'hC00000, 1'b0, 1'b0);
    send(32'h80000000);
    idle();
    idle();
    chk_out("negzero", 1'b1, 24'h000000, 24'hC00000, 1'b0, 1'b0);

    // Out of range
    send(32'h43960000);
    idle();
    idle();
    chk_out("big300", 1'b1, 24'hFFFFFF, 24'h3FFFFF, 1'b1, 1'b1);
    send(32'hBF800000);
    idle();
    idle();
    chk_out("neg1", 1'b1, 24'h000000, 24'hC00000, 1'b1, 1'b1);

    // Half-LSB operand
    send(32'h37000000);
    idle();
    idle();
    chk_out("round", 1'b1, ROUND_EXP, 24'hC00000, 1'b0, 1'b1);

    // Stream with a 2-cycle clk_en drop after the 4th sample; ignored inputs during the stall
    pipe = '{-1, -1, -1};
    k    = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      en     = !(cyc == 4 || cyc == 5);
      clk_en = en;
      if (!en) begin
        bus.in_valid = 1'b1;
        bus.dataa    = 32'h43960000;
      end else if (k < 11) begin
        bus.in_valid = 1'b1;
        bus.dataa    = stall_vec[k];
      end else begin
        bus.in_valid = 1'b0;
        bus.dataa    = 32'h0;
      end
      step();
      if (en) begin
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = (k < 11) ? k : -1;
        if (k < 11) k++;
      end
      if (pipe[2] >= 0) begin
        xe = 24'((pipe[2] * 25) << 16);
        chk_out($sformatf("stall%0d", pipe[2]), 1'b1, xe, exp_theta(xe), 1'b0, 1'b1);
      end else begin
        chk_out("stall_bubble", 1'b0, 24'h0, 24'h0, 1'b0, 1'b1);
      end
    end
    clk_en = 1'b1;

    // Reset with three samples in flight, asserted while clk_en is low
    send(32'h41C80000);
    send(32'h42480000);
    send(32'h42960000);
    chk_out("pre_reset", 1'b1, 24'h190000, 24'hCC8000, 1'b0, 1'b1);
    clk_en       = 1'b0;
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    #1;
    chk_zero("async_reset");
    step();
    reset  = 1'b0;
    clk_en = 1'b1;
    idle();
    chk_out("post_reset1", 1'b0, 24'h0, 24'h0, 1'b0, 1'b0);
    idle();
    chk_out("post_reset2", 1'b0, 24'h0, 24'h0, 1'b0, 1'b0);
    idle();
    chk_out("post_reset3", 1'b0, 24'h0, 24'h0, 1'b0, 1'b0);
    send(32'h42960000);
    idle();
    idle();
    chk_out("after_reset75", 1'b1, 24'h4B0000, 24'hE58000, 1'b0, 1'b0);
    idle();
    chk_out("after_reset_bubble", 1'b0, 24'h0, 24'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_input_stage.md
# cordic_input_stage

Pipelined front end of the cosine CORDIC accelerator. Converts the IEEE-754 single-precision operand x (valid range 0.0 ≤ x < 256.0) into two fixed-point values:
- x_fixed, used by the x and x² datapath.
- theta = (x − 128)/128, the angle fed to the CORDIC inner pipeline.

It sits directly upstream of the inner pipeline and shares its clk/clk_en stall discipline.

## Interface
Parameters:
- none; all widths are fixed by the inner pipeline's input format.

Ports:
- clk  in  1  system clock (50 MHz), all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- clk_en  in  1  pipeline advance enable; low = every stage holds
- in_valid  in  1  dataa carries a sample; sampled only when clk_en=1
- dataa  in  32  IEEE-754 single operand x
- out_valid  out  1  x_fixed/theta/range_err carry a sample
- x_fixed  out  24  unsigned Q8.16 of x
- theta  out  24  signed two's-complement Q1.22 of (x−128)/128
- range_err  out  1  this sample was out of range and saturated
- err_sticky  out  1  OR of every range_err since reset

## Operation
- **Stage 1 (unpack):** register sign s, exponent e, mantissa M = {1, frac}; M is Q1.23.
  - Class flags: zero/denormal (e=0), neg (s=1 and not zero), big (e ≥ 135, which includes Inf/NaN).
- **Stage 2 (convert):**
  - x_fixed = M >> (134 − e). A shift ≥ 24 gives 0. Truncation toward zero.
  - zero/denormal → 0; −0.0 is treated as zero and is not an error.
  - neg → 0 with range_err=1.
  - big → 0xFFFFFF with range_err=1.
- **Stage 3 (angle):**
  - theta = (x_fixed − 0x800000) >>> 1, computed as a 25-bit signed subtract followed by an arithmetic shift, with the low 24 bits kept.
  - Range is 0xC00000 (−1.0) to 0x3FFFFF.
  - All outputs are registered.
- Valid bits travel with the data, one per stage. A bubble (in_valid=0) propagates as out_valid=0; the data registers of an invalid stage are don't-care.
- err_sticky sets on any cycle where out_valid=1 and range_err=1 are being registered. It clears only on reset.

## Timing
- Latency: exactly 3 enabled cycles (clk_en=1 edges) from in_valid/dataa sampled to out_valid.
- Throughput: one sample per enabled cycle; there is no backpressure other than clk_en.
- clk_en=0:
  - Every register holds, including valid bits and err_sticky.
  - Inputs are ignored.
  - Outputs stay stable for the whole stall.
- Reset value of every output is 0: out_valid, x_fixed, theta, range_err, err_sticky.
- Reset takes effect immediately, asynchronously, and discards all in-flight samples. The first sample accepted after reset release appears 3 enabled cycles later.
- If reset is asserted while clk_en=0, state still clears.

## Configuration
- CORDIC_INPUT_ROUND_EN defined:
  - The stage-2 shift rounds half-up: the last shifted-out bit is added to the result.
  - If rounding overflows 0xFFFFFF, the result saturates to 0xFFFFFF and range_err stays 0.
- Undefined: plain truncation as above. Latency is identical in both builds.

## Test plan
- **Nominal:** 25.0 (0x41C80000), 128.0 (0x43000000), 255.0 (0x437F0000) applied back-to-back with clk_en=1. Expected, starting 3 cycles later:
  - x_fixed = 0x190000, 0x800000, 0xFF0000.
  - theta = 0xCC8000, 0x000000, 0x3F8000.
  - range_err = 0.
- **Boundaries:**
  - 0.0 (0x00000000) → x_fixed 0, theta 0xC00000, range_err 0.
  - −0.0 (0x80000000) → same values, range_err 0.
- **Out of range:**
  - 300.0 (0x43960000) → x_fixed 0xFFFFFF, theta 0x3FFFFF, range_err 1, err_sticky 1.
  - −1.0 (0xBF800000) → x_fixed 0, theta 0xC00000, range_err 1.
- **Stall:**
  - Stimulus: inputs 0, 25, 50 … 250 (11 samples); drop clk_en for 2 cycles after the 4th.
  - Required: outputs stay frozen during the stall, order is preserved, all 11 samples appear, and each has latency of 3 enabled cycles.
- **Reset mid-flight:**
  - Stimulus: assert reset for one cycle with 3 samples in flight.
  - Required: all outputs read 0 immediately; no stale out_valid afterwards; a new 75.0 → x_fixed 0x4B0000, theta 0xE58000 three cycles later.
- **Rounding:** 2⁻¹⁷ (0x37000000) → x_fixed 0x000000 without CORDIC_INPUT_ROUND_EN, 0x000001 with it.
